// File: rtl/nco_clken_pkg.sv
// nco_clken_pkg
//   Shared types and constants for the NCO clock-enable generator.
//   - ACC_W_DEFAULT : default phase-accumulator width
//   - MAX_ACC_W     : widest accumulator the cfg_t record can carry
//   - MAX_CLOCKS    : upper bound on channels (cfg_sel is 4 bits wide)
//   - cfg_t         : one configuration write {sel, incr, phase}
package nco_clken_pkg;

  localparam int ACC_W_DEFAULT = 32;
  localparam int MAX_ACC_W     = 64;
  localparam int MAX_CLOCKS    = 16;
  localparam int SEL_W         = 4;

  typedef struct packed {
    logic [SEL_W-1:0]     sel;
    logic [MAX_ACC_W-1:0] incr;
    logic [MAX_ACC_W-1:0] phase;
  } cfg_t;

  // True when sel addresses an instantiated channel.
  function automatic logic sel_in_range(logic [SEL_W-1:0] sel, int num_clocks);
    return int'(sel) < num_clocks;
  endfunction

endpackage

// File: rtl/nco_clken_ch.sv
// nco_clken_ch
//   One NCO channel: fractional phase accumulator with its own increment and
//   stored phase offset. Emits a one-cycle strobe per accumulator overflow and
//   the registered accumulator MSB as a ~50% duty divided clock.
// Ports:
//   clk_i, srst_i      clock, synchronous active-high reset
//   load_i             write incr_i/phase_i and restart the accumulator at phase_i
//   align_i            restart the accumulator at the stored phase
//   incr_i, phase_i    new increment / phase offset (used with load_i)
//   clken_o            overflow strobe (registered)
//   outclk_o           accumulator MSB (registered)
module nco_clken_ch #(
  parameter int               ACC_W     = 32,
  parameter logic [ACC_W-1:0] INIT_INCR = {2'b01, {(ACC_W-2){1'b0}}}
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             load_i,
  input  logic             align_i,
  input  logic [ACC_W-1:0] incr_i,
  input  logic [ACC_W-1:0] phase_i,
  output logic             clken_o,
  output logic             outclk_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] incr_q, incr_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic             clken_q, clken_d;
  logic             outclk_q, outclk_d;
  logic [ACC_W:0]   sum;

  // Extra top bit of the sum is the overflow carry.
  assign sum = {1'b0, acc_q} + {1'b0, incr_q};

  always_comb begin
    acc_d    = sum[ACC_W-1:0];
    clken_d  = sum[ACC_W];
    outclk_d = sum[ACC_W-1];
    incr_d   = incr_q;
    phase_d  = phase_q;
    // A write wins over align so that a simultaneous write+align starts
    // this channel at the freshly written phase.
    if (load_i) begin
      incr_d   = incr_i;
      phase_d  = phase_i;
      acc_d    = phase_i;
      clken_d  = 1'b0;
      outclk_d = phase_i[ACC_W-1];
    end else if (align_i) begin
      acc_d    = phase_q;
      clken_d  = 1'b0;
      outclk_d = phase_q[ACC_W-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_q    <= '0;
      incr_q   <= INIT_INCR;
      phase_q  <= '0;
      clken_q  <= 1'b0;
      outclk_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      incr_q   <= incr_d;
      phase_q  <= phase_d;
      clken_q  <= clken_d;
      outclk_q <= outclk_d;
    end
  end

  assign clken_o  = clken_q;
  assign outclk_o = outclk_q;

endmodule

// File: rtl/nco_clken_gen.sv
// nco_clken_gen
//   Runtime-programmable multi-channel clock-enable generator. Each channel
//   is an NCO (f_out = f_refclk * incr / 2^ACC_W). A lock flag rises once the
//   configuration has been left alone for LOCK_CYCLES cycles.
//   ACC_W must not exceed nco_clken_pkg::MAX_ACC_W.
// Ports:
//   refclk             sole clock
//   rst                synchronous active-high reset
//   cfg_wr/cfg_sel     configuration write strobe / target channel
//   cfg_incr/cfg_phase new increment / phase offset for the target channel
//   align              reload every accumulator with its stored phase
//   clken[N]           per-channel overflow strobes
//   outclk[N]          per-channel divided clocks
//   cfg_err            one-cycle pulse on a write to a nonexistent channel
//   locked             configuration stable for LOCK_CYCLES cycles
module nco_clken_gen
  import nco_clken_pkg::*;
#(
  parameter int               NUM_CLOCKS  = 2,
  parameter int               ACC_W       = ACC_W_DEFAULT,
  parameter logic [ACC_W-1:0] INIT_INCR   = {2'b01, {(ACC_W-2){1'b0}}},
  parameter int               LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [3:0]            cfg_sel,
  input  logic [ACC_W-1:0]      cfg_incr,
  input  logic [ACC_W-1:0]      cfg_phase,
  input  logic                  align,
  output logic [NUM_CLOCKS-1:0] clken,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  cfg_err,
  output logic                  locked
);

  localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  cfg_t cfg_s;
  logic cfg_valid;
  logic wr_ok;
  logic unused_cfg_bits;

  always_comb begin
    cfg_s.sel   = cfg_sel;
    cfg_s.incr  = MAX_ACC_W'(cfg_incr);
    cfg_s.phase = MAX_ACC_W'(cfg_phase);
  end

  // Bits above ACC_W in the record are zero padding.
  assign unused_cfg_bits = ^{cfg_s.incr, cfg_s.phase};

  assign cfg_valid = sel_in_range(cfg_s.sel, NUM_CLOCKS);
  assign wr_ok     = cfg_wr & cfg_valid;

  generate
    for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
      logic load;
      assign load = wr_ok && (cfg_s.sel == SEL_W'(gi));

      nco_clken_ch #(
        .ACC_W     (ACC_W),
        .INIT_INCR (INIT_INCR)
      ) u_ch (
        .clk_i    (refclk),
        .srst_i   (rst),
        .load_i   (load),
        .align_i  (align),
        .incr_i   (cfg_s.incr[ACC_W-1:0]),
        .phase_i  (cfg_s.phase[ACC_W-1:0]),
        .clken_o  (clken[gi]),
        .outclk_o (outclk[gi])
      );
    end
  endgenerate

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             cfg_err_q, cfg_err_d;

  always_comb begin
    cfg_err_d  = cfg_wr & ~cfg_valid;
    lock_cnt_d = lock_cnt_q;
    // Any change to the channel timing restarts the stability window;
    // rejected writes leave it running.
    if (wr_ok || align) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q < LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
    locked_d = (lock_cnt_d == LOCK_MAX);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_nco_clken_gen.sv
module tb_nco_clken_gen;

  localparam int NCH   = 2;
  localparam int AW    = 8;
  localparam int MODV  = 256;
  localparam int HALF  = 128;
  localparam int INITI = 64;
  localparam int LOCKN = 16;

  logic           refclk = 1'b0;
  logic           rst;
  logic           cfg_wr;
  logic [3:0]     cfg_sel;
  logic [AW-1:0]  cfg_incr;
  logic [AW-1:0]  cfg_phase;
  logic           align;
  logic [NCH-1:0] clken;
  logic [NCH-1:0] outclk;
  logic           cfg_err;
  logic           locked;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: each channel's phase as an integer fraction of MODV.
  int m_acc   [NCH];
  int m_incr  [NCH];
  int m_phase [NCH];
  bit m_clken [NCH];
  bit m_outclk[NCH];
  bit m_err;
  int m_quiet;   // edges since the last reset / accepted write / align

  always #5 refclk = ~refclk;

  nco_clken_gen #(
    .NUM_CLOCKS  (NCH),
    .ACC_W       (AW),
    .INIT_INCR   (8'd64),
    .LOCK_CYCLES (LOCKN)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_sel   (cfg_sel),
    .cfg_incr  (cfg_incr),
    .cfg_phase (cfg_phase),
    .align     (align),
    .clken     (clken),
    .outclk    (outclk),
    .cfg_err   (cfg_err),
    .locked    (locked)
  );

  task automatic model_edge(bit r, bit w, int sel, int inc, int ph, bit al);
    bit acc_wr;
    int s;
    acc_wr = w && (sel < NCH);
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0; m_incr[i] = INITI; m_phase[i] = 0;
        m_clken[i] = 0; m_outclk[i] = 0;
      end
      m_err = 0;
      m_quiet = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (acc_wr && sel == i) begin
          m_incr[i] = inc; m_phase[i] = ph; m_acc[i] = ph;
          m_clken[i] = 0; m_outclk[i] = (ph >= HALF);
        end else if (al) begin
          m_acc[i] = m_phase[i]; m_clken[i] = 0; m_outclk[i] = (m_acc[i] >= HALF);
        end else begin
          s = m_acc[i] + m_incr[i];
          m_clken[i] = (s >= MODV);
          m_acc[i] = s % MODV;
          m_outclk[i] = (m_acc[i] >= HALF);
        end
      end
      m_err = w && !(sel < NCH);
      if (acc_wr || al) m_quiet = 0;
      else if (m_quiet < LOCKN) m_quiet++;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit w, int sel, int inc, int ph, bit al);
    int inc_m, ph_m;
    inc_m = inc % MODV;
    ph_m  = ph % MODV;
    rst = r; cfg_wr = w; cfg_sel = 4'(sel);
    cfg_incr = AW'(inc_m); cfg_phase = AW'(ph_m); align = al;
    @(posedge refclk);
    model_edge(r, w, sel, inc_m, ph_m, al);
    @(negedge refclk);
    vectors++;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("clken[%0d] v%0d", i, vectors), 32'(clken[i]), 32'(m_clken[i]));
      chk($sformatf("outclk[%0d] v%0d", i, vectors), 32'(outclk[i]), 32'(m_outclk[i]));
    end
    chk($sformatf("cfg_err v%0d", vectors), 32'(cfg_err), 32'(m_err));
    chk($sformatf("locked v%0d", vectors), 32'(locked), 32'(m_quiet >= LOCKN));
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int first, lock_at, cnt, f0, f1;
    bit r, w, al;
    int sel, inc, ph;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_clken", 32'(clken), 32'(0));
    chk("reset_locked", 32'(locked), 32'(0));

    // 1: default rate f/4, lock latency after release
    first = -1; lock_at = -1;
    for (int k = 1; k <= 40 && lock_at < 0; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (clken[0] === 1'b1 && first < 0) first = k;
      if (locked === 1'b1) lock_at = k;
    end
    chk("s1_first_clken", 32'(first), 32'(4));
    chk("s1_lock_edges", 32'(lock_at), 32'(LOCKN));

    // 2: fractional rate 96/256 -> 300 pulses in 800 cycles
    step(0, 1, 0, 96, 0, 0);
    chk("s2_locked_drop", 32'(locked), 32'(0));
    cnt = 0;
    repeat (800) begin
      step(0, 0, 0, 0, 0, 0);
      if (clken[0] === 1'b1) cnt++;
    end
    chk("s2_pulses", 32'(cnt), 32'(300));

    // 3: phase offset then align
    step(0, 1, 0, 64, 0, 0);
    step(0, 1, 1, 64, 128, 0);
    step(0, 0, 0, 0, 0, 1);
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (clken[0] === 1'b1 && f0 < 0) f0 = k;
      if (clken[1] === 1'b1 && f1 < 0) f1 = k;
    end
    chk("s3_ch1_first", 32'(f1), 32'(2));
    chk("s3_ch0_first", 32'(f0), 32'(4));
    idle(12);

    // 4: channel off with MSB set
    step(0, 1, 1, 0, 128, 0);
    idle(20);
    chk("s4_outclk1", 32'(outclk[1]), 32'(1));

    // 5: out-of-range select while locked
    chk("s5_pre_locked", 32'(locked), 32'(1));
    step(0, 1, 5, 33, 77, 0);
    chk("s5_cfg_err", 32'(cfg_err), 32'(1));
    chk("s5_locked_kept", 32'(locked), 32'(1));
    step(0, 0, 0, 0, 0, 0);
    chk("s5_err_pulse_end", 32'(cfg_err), 32'(0));
    idle(6);

    // 6: reset wins over a simultaneous write and align
    step(1, 1, 0, 200, 50, 1);
    chk("s6_clken", 32'(clken), 32'(0));
    chk("s6_outclk", 32'(outclk), 32'(0));
    chk("s6_cfg_err", 32'(cfg_err), 32'(0));
    first = -1; lock_at = -1;
    for (int k = 1; k <= 40 && lock_at < 0; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (clken[0] === 1'b1 && first < 0) first = k;
      if (locked === 1'b1) lock_at = k;
    end
    chk("s6_first_clken", 32'(first), 32'(4));
    chk("s6_lock_edges", 32'(lock_at), 32'(LOCKN));

    // Randomized traffic against the model
    repeat (1500) begin
      r   = ($urandom_range(0, 199) == 0);
      w   = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       inc = 0;
        1:       inc = $urandom_range(128, 255);
        default: inc = $urandom_range(1, 127);
      endcase
      ph  = $urandom_range(0, 255);
      al  = ($urandom_range(0, 29) == 0);
      step(r, w, sel, inc, ph, al);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
